audio_noise_reducer: RTL and testbench

- Streaming 16-bit signed PCM denoiser placed on the audio path after the noise-injection stage and before the codec/reverb path.
- An 8-tap (parameterised) moving-average low-pass stage suppresses broadband noise.
- A noise gate with a hold counter then mutes residual low-level noise between passages.
- Processes one sample per in_valid strobe, with fixed latency and no backpressure.

---
 rtl/audio_noise_reducer.sv | 160 ++++++++++++++++
 tb/tb_audio_noise_reducer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/audio_noise_reducer.sv
// Streaming PCM denoiser: N-tap moving average followed by a noise gate
// with hold time. One sample per in_valid strobe, fixed 2-cycle latency.
//
// Ports:
//   CLK        rising-edge clock
//   RST        synchronous active-high reset
//   in_valid   audio_in carries a new sample
//   audio_in   16-bit signed sample
//   bypass     emit the delayed raw sample instead of the processed one
//   out_valid  single-cycle pulse, audio_out updated
//   audio_out  16-bit signed output sample
//   gate_open  gate is OPEN or HOLD
module audio_noise_reducer #(
    parameter int LOG2_TAPS    = 3,
    parameter int GATE_THRESH  = 256,
    parameter int HOLD_SAMPLES = 64
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    input  logic signed [15:0] audio_in,
    input  logic               bypass,
    output logic               out_valid,
    output logic signed [15:0] audio_out,
    output logic               gate_open
);

    localparam int N  = 1 << LOG2_TAPS;
    localparam int SW = 16 + LOG2_TAPS;
    localparam int HW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;

    localparam logic [14:0]   THR       = 15'(GATE_THRESH);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_SAMPLES - 1);

    typedef enum logic [1:0] {
        CLOSED,
        OPEN,
        HOLD
    } gate_t;

    // Stage 1 state
    logic signed [15:0]    tap [N];
    logic [LOG2_TAPS-1:0]  wr_ptr;
    logic signed [SW-1:0]  sum_q;
    logic signed [15:0]    raw_q;
    logic                  byp_q;
    logic                  v1;

    // Gate state
    gate_t                 state_q, state_d;
    logic [HW-1:0]         cnt_q, cnt_d;

    // Stage 2 combinational values
    logic signed [15:0]    avg;
    logic signed [15:0]    neg;
    logic [14:0]           mag;
    logic                  above;
    logic signed [15:0]    sel;

    logic signed [SW-1:0]  in_ext;
    logic signed [SW-1:0]  old_ext;

    assign in_ext  = {{LOG2_TAPS{audio_in[15]}}, audio_in};
    assign old_ext = {{LOG2_TAPS{tap[wr_ptr][15]}}, tap[wr_ptr]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < N; i++) begin
                tap[i] <= '0;
            end
            wr_ptr <= '0;
            sum_q  <= '0;
            raw_q  <= '0;
            byp_q  <= 1'b0;
            v1     <= 1'b0;
        end else begin
            v1 <= in_valid;
            if (in_valid) begin
                sum_q       <= sum_q + in_ext - old_ext;
                tap[wr_ptr] <= audio_in;
                wr_ptr      <= wr_ptr + 1'b1;
                raw_q       <= audio_in;
                byp_q       <= bypass;
            end
        end
    end

    // The divided sum of N 16-bit samples always fits back into 16 bits.
    assign avg = 16'(sum_q >>> LOG2_TAPS);
    assign neg = -avg;

    always_comb begin
        mag = avg[14:0];
        if (avg == 16'sh8000) begin
            mag = 15'h7fff;
        end else if (avg[15]) begin
            mag = neg[14:0];
        end
    end

    assign above = (mag >= THR);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLOSED: begin
                if (above) begin
                    state_d = OPEN;
                end
            end
            OPEN: begin
                if (!above) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_INIT;
                end
            end
            HOLD: begin
                if (above) begin
                    state_d = OPEN;
                end else if (cnt_q == '0) begin
                    state_d = CLOSED;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = CLOSED;
            end
        endcase
    end

    always_comb begin
        sel = avg;
        if (byp_q) begin
            sel = raw_q;
        end else if (state_d == CLOSED) begin
            sel = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= CLOSED;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            audio_out <= '0;
            gate_open <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                audio_out <= sel;
                gate_open <= (state_d != CLOSED);
            end
        end
    end

endmodule

// File: tb/tb_audio_noise_reducer.sv
// Directed table-driven bench for audio_noise_reducer.
// Each record drives one cycle; its expected output is checked 2 cycles later.
module tb_audio_noise_reducer;

    logic               CLK;
    logic               RST;
    logic               in_valid;
    logic signed [15:0] audio_in;
    logic               bypass;
    logic               out_valid;
    logic signed [15:0] audio_out;
    logic               gate_open;

    audio_noise_reducer dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .audio_in  (audio_in),
        .bypass    (bypass),
        .out_valid (out_valid),
        .audio_out (audio_out),
        .gate_open (gate_open)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic v;
        int   d;
        logic b;
        logic r;
        int   eo;
        logic eg;
    } vec_t;

    // kind: 0 = nothing, 1 = sample output, 2 = reset takes effect
    typedef struct {
        int   kind;
        int   eo;
        logic eg;
    } slot_t;

    vec_t  tbl[$];
    slot_t s1, s2;
    int    checks = 0;
    int    errors = 0;
    int    stepn  = 0;
    int    last_o = 0;
    logic  last_g = 1'b0;

    function automatic void add(logic v, int d, logic b, logic r,
                                int eo, logic eg);
        vec_t e;
        e.v = v; e.d = d; e.b = b; e.r = r; e.eo = eo; e.eg = eg;
        tbl.push_back(e);
    endfunction

    function automatic void idle(int n);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s step %0d got %0d want %0d", nm, stepn, act, exp);
        end
    endtask

    task automatic step(vec_t e);
        slot_t n;
        @(posedge CLK);
        #1;
        if (s2.kind == 2) begin
            last_o = 0;
            last_g = 1'b0;
        end else if (s2.kind == 1) begin
            last_o = s2.eo;
            last_g = s2.eg;
        end
        chk("out_valid", int'(out_valid), (s2.kind == 1) ? 1 : 0);
        chk("audio_out", int'(audio_out), last_o);
        chk("gate_open", int'(gate_open), int'(last_g));
        s2 = s1;
        if (e.r) s2.kind = 2;
        n.kind = (e.v && !e.r) ? 1 : 0;
        n.eo   = e.eo;
        n.eg   = e.eg;
        s1 = n;
        RST      = e.r;
        in_valid = e.v;
        audio_in = 16'(e.d);
        bypass   = e.b;
        stepn++;
    endtask

    initial begin
        vec_t e;
        RST = 1'b1;
        in_valid = 1'b0;
        audio_in = '0;
        bypass = 1'b0;
        s1.kind = 0; s1.eo = 0; s1.eg = 0;
        s2 = s1;

        // power-up reset
        add(0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        // ramp of 1000s: gate opens on the 3rd output
        add(1, 1000, 0, 0, 0, 0);
        add(1, 1000, 0, 0, 0, 0);
        add(1, 1000, 0, 0, 375, 1);
        add(1, 1000, 0, 0, 500, 1);
        add(1, 1000, 0, 0, 625, 1);
        add(1, 1000, 0, 0, 750, 1);
        add(1, 1000, 0, 0, 875, 1);
        add(1, 1000, 0, 0, 1000, 1);
        // decay of zeros: HOLD from #6, closes at #70
        for (int n = 1; n <= 70; n++) begin
            int a;
            a = (n < 8) ? 1000 - 125 * n : 0;
            if (n < 70) add(1, 0, 0, 0, a, 1);
            else        add(1, 0, 0, 0, 0, 0);
        end
        // full-scale negative input, no wrap after saturation
        for (int k = 1; k <= 8; k++) add(1, -32768, 0, 0, -4096 * k, 1);
        // bypass with the gate closed
        idle(2);
        add(0, 0, 0, 1, 0, 0);
        add(1, 5, 1, 0, 5, 0);
        add(1, -7, 1, 0, -7, 0);
        add(1, 300, 1, 0, 300, 0);
        // gapped ramp, strobe every 3rd cycle
        idle(2);
        add(0, 0, 0, 1, 0, 0);
        begin
            int ex [8] = '{0, 0, 375, 500, 625, 750, 875, 1000};
            for (int k = 0; k < 8; k++) begin
                add(1, 1000, 0, 0, ex[k], (k >= 2));
                idle(2);
            end
        end

        foreach (tbl[i]) begin
            e = tbl[i];
            step(e);
        end

        // reset with the gate open and a sample in flight
        e.v = 1; e.d = 1000; e.b = 0; e.r = 0; e.eo = 1000; e.eg = 1;
        step(e);
        e.v = 0; e.d = 0; e.r = 1; e.eo = 0; e.eg = 0;
        step(e);
        e.v = 1; e.d = 1000; e.r = 0; e.eo = 0; e.eg = 0;
        step(e);
        e.v = 0; e.d = 0;
        for (int i = 0; i < 4; i++) step(e);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
